// File: rtl/de2i_150_qsys_pio_in_capture.sv
`default_nettype none
// ============================================================================
// Module  : de2i_150_qsys_pio_in_capture
// Brief   : Avalon-MM input PIO: synchronizer, sticky edge capture, masked IRQ.
//           Macro PIO_IN_BITCLR_EN selects write-1-to-clear for EDGECAP.
// Revision: 1.0
// ============================================================================
module de2i_150_qsys_pio_in_capture #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [WIDTH-1:0]  in_port,
    output logic              irq
);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] cap_clr;
    logic             wr_en;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign wr_en    = chipselect & ~write_n;

    generate
        if (EDGE_TYPE == 0) begin : g_edge_rise
            assign edge_det = sync_out & ~prev_q;
        end else if (EDGE_TYPE == 1) begin : g_edge_fall
            assign edge_det = ~sync_out & prev_q;
        end else begin : g_edge_any
            assign edge_det = sync_out ^ prev_q;
        end
    endgenerate

`ifdef PIO_IN_BITCLR_EN
    assign cap_clr = (wr_en && (address == ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;
`else
    assign cap_clr = (wr_en && (address == ADDR_EDGECAP)) ? '1 : '0;
`endif

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], in_port};
        prev_d     = sync_out;
        irq_mask_d = irq_mask_q;
        if (wr_en && (address == ADDR_IRQMASK)) begin
            irq_mask_d = writedata[WIDTH-1:0];
        end
        // OR-ing the new edges in after the clear gives set priority.
        edge_capture_d = (edge_capture_q & ~cap_clr) | edge_det;

        readdata_d = '0;
        case (address)
            ADDR_DATA:    readdata_d[WIDTH-1:0] = sync_out;
            ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irq_mask_q;
            ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edge_capture_q;
            default:      readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q         <= '0;
            prev_q         <= '0;
            edge_capture_q <= '0;
            irq_mask_q     <= '0;
            readdata_q     <= '0;
        end else begin
            sync_q         <= sync_d;
            prev_q         <= prev_d;
            edge_capture_q <= edge_capture_d;
            irq_mask_q     <= irq_mask_d;
            readdata_q     <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_capture_q & irq_mask_q);

endmodule
`default_nettype wire
